// File: rtl/avmm_pio_master_if.sv
// rtl/avmm_pio_master_if.sv - command, response and Avalon-MM bus bundle for the PIO master
interface avmm_pio_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) ();

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_poll;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;

  // Avalon-MM initiator side
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  // response channel and status
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
    input  readdata, rsp_ready,
    output cmd_ready, address, chipselect, write_n, read_n, writedata,
    output rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
    output readdata, rsp_ready,
    input  cmd_ready, address, chipselect, write_n, read_n, writedata,
    input  rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/avmm_pio_master.sv
// rtl/avmm_pio_master.sv - single-beat Avalon-MM PIO initiator with hardware poll
module avmm_pio_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int POLL_LIMIT   = 1024,
  parameter int POLL_GAP     = 4
) (
  input logic               clk,
  input logic               reset_n,
  avmm_pio_master_if.master bus
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_READ = CNT_W'(POLL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAT_LOAD  = 3'(READ_LATENCY - 1);
  localparam logic [7:0]       GAP_LOAD  = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  typedef enum logic [2:0] {IDLE, XFER, RWAIT, GAP, RSP} state_t;

  state_t            state_q, state_d;
  logic              op_write_q, op_write_d;
  logic              op_poll_q, op_poll_d;
  logic [DATA_W-1:0] match_q, match_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cs_q, cs_d;
  logic              write_n_q, write_n_d;
  logic              read_n_q, read_n_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic [2:0]        lat_q, lat_d;
  logic [7:0]        gap_q, gap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit;

  // Poll compare on the word arriving this cycle
  assign hit = ((bus.readdata ^ match_q) & mask_q) == '0;

  // Next-state and next-output logic; every bus output is registered from these
  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    op_poll_d   = op_poll_q;
    match_d     = match_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    read_n_d    = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    lat_d       = lat_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_write_d = bus.cmd_write;
          op_poll_d  = bus.cmd_poll & ~bus.cmd_write;
          match_d    = bus.cmd_wdata;
          mask_d     = bus.cmd_mask;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          cs_d       = 1'b1;
          write_n_d  = ~bus.cmd_write;
          read_n_d   = bus.cmd_write;
          cnt_d      = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        if (op_write_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = RWAIT;
        end
      end

      RWAIT: begin
        if (lat_q != 3'd0) begin
          lat_d = lat_q - 3'd1;
        end else if (!op_poll_q || hit || cnt_q == LAST_READ) begin
          // A non-matching poll can only land here once the read limit is hit
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.readdata;
          rsp_err_d   = op_poll_q & ~hit;
          state_d     = RSP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (POLL_GAP == 0) begin
            cs_d     = 1'b1;
            read_n_d = 1'b0;
            state_d  = XFER;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          cs_d     = 1'b1;
          read_n_d = 1'b0;
          state_d  = XFER;
        end
      end

      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      op_poll_q   <= 1'b0;
      match_q     <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      lat_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      op_poll_q   <= op_poll_d;
      match_q     <= match_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      lat_q       <= lat_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.address    = addr_q;
  assign bus.chipselect = cs_q;
  assign bus.write_n    = write_n_q;
  assign bus.read_n     = read_n_q;
  assign bus.writedata  = wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_avmm_pio_master.sv
// tb/tb_avmm_pio_master.sv - randomized self-checking bench for avmm_pio_master
module tb_avmm_pio_master;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int RL     = 1;
  localparam int LIMIT  = 8;
  localparam int GAPC   = 2;
  localparam int PERIOD = GAPC + 1 + RL;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  avmm_pio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avmm_pio_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL),
    .POLL_LIMIT(LIMIT), .POLL_GAP(GAPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave register behaviour: each read of an address returns the stored word with
  // the per-address read index in bits 31:16 and bit 0 flipped from read index 'fl' on.
  function automatic logic [31:0] rd_val(input logic [31:0] m, input int r, input int fl);
    logic [31:0] rr;
    rr = r;
    return m ^ {rr[15:0], 15'd0, (r >= fl)};
  endfunction

  int flip [4] = '{default: 1000};

  // Fixed-latency (1) PIO slave
  logic [31:0] mem_s [4] = '{default: 32'h0};
  int          rcnt_s [4] = '{default: 0};
  always @(posedge clk) begin
    if (bus.chipselect && !bus.write_n) begin
      mem_s[bus.address]  <= bus.writedata;
      rcnt_s[bus.address] <= 0;
    end
    if (bus.chipselect && !bus.read_n) begin
      bus.readdata        <= rd_val(mem_s[bus.address], rcnt_s[bus.address], flip[bus.address]);
      rcnt_s[bus.address] <= rcnt_s[bus.address] + 1;
    end
  end

  // Response backpressure
  bit hold_low = 1'b0;
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: expected bus cycles keyed by absolute cycle, one response per command
  typedef struct {
    int          id;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } ev_t;

  ev_t         exp_bus [int];
  int          n_acc = 0;
  int          exp_start = 0;
  logic [31:0] exp_data = 0;
  bit          exp_err = 0;
  int          last_e = 0;

  int          n_done = 0;
  int          abort_mark = 0;
  logic [31:0] mem_m [4] = '{default: 32'h0};
  int          rcnt_m [4] = '{default: 0};
  logic [1:0]  last_addr = 2'd0;
  int          n_strobes = 0;
  int          last_strobe = -100;
  int          strobe_gap = 0;
  int          rsp_first = 0;
  int          n_rsp = 0;
  logic [31:0] got_data = 0;
  bit          got_err = 0;
  bit          prev_valid = 0;

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    bit  pend;
    bit  exp_v;
    ev_t ev;
    if (!reset_n) begin
      chk("rst_chipselect", bus.chipselect, 0);
      chk("rst_write_n", bus.write_n, 1);
      chk("rst_read_n", bus.read_n, 1);
      chk("rst_address", bus.address, 0);
      chk("rst_writedata", bus.writedata, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      abort_mark = n_acc;
      n_done     = n_acc;
      last_addr  = 2'd0;
      prev_valid = 1'b0;
    end else begin
      pend = (n_acc != n_done);
      if (exp_bus.exists(cyc) && exp_bus[cyc].id > abort_mark) begin
        ev = exp_bus[cyc];
        chk("bus_chipselect", bus.chipselect, 1);
        chk("bus_write_n", bus.write_n, !ev.wr);
        chk("bus_read_n", bus.read_n, ev.wr);
        chk("bus_address", bus.address, ev.addr);
        if (ev.wr) begin
          chk("bus_writedata", bus.writedata, ev.wdata);
          mem_m[ev.addr]  = ev.wdata;
          rcnt_m[ev.addr] = 0;
        end else begin
          rcnt_m[ev.addr] = rcnt_m[ev.addr] + 1;
          n_strobes++;
          strobe_gap  = cyc - last_strobe;
          last_strobe = cyc;
        end
        last_addr = ev.addr;
      end else begin
        chk("idle_chipselect", bus.chipselect, 0);
        chk("idle_write_n", bus.write_n, 1);
        chk("idle_read_n", bus.read_n, 1);
        chk("hold_address", bus.address, last_addr);
      end
      chk("cmd_ready", bus.cmd_ready, !pend);
      chk("busy", bus.busy, pend);
      exp_v = pend && (cyc >= exp_start);
      chk("rsp_valid", bus.rsp_valid, exp_v);
      if (bus.rsp_valid && !prev_valid) rsp_first = cyc;
      prev_valid = bus.rsp_valid;
      if (exp_v) begin
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", bus.rsp_err, exp_err);
        if (bus.rsp_ready) begin
          got_data = bus.rsp_data;
          got_err  = bus.rsp_err;
          n_rsp++;
          n_done++;
        end
      end
    end
  end

  // Offer one command, wait for acceptance, and record what the bus and response must do
  task automatic issue(input bit wr, input bit pl, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] mk);
    int          c;
    int          g;
    int          k;
    int          id;
    bit          r;
    bit          hitm;
    logic [31:0] v;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_poll  = pl;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_mask  = mk;
    g = 0;
    r = 1'b0;
    c = 0;
    while (!r && g < 200) begin
      @(negedge clk);
      r = bus.cmd_ready;
      c = cyc;
      @(posedge clk);
      g++;
    end
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
    bus.cmd_addr  = 2'($urandom);
    chk("accept_timeout", r, 1);
    if (!r) return;
    last_e = c + 1;
    id = n_acc + 1;
    if (wr) begin
      exp_bus[last_e] = '{id, 1'b1, a, wd};
      exp_start = last_e + 1;
      exp_data  = 32'h0;
      exp_err   = 1'b0;
    end else if (!pl) begin
      exp_bus[last_e] = '{id, 1'b0, a, 32'h0};
      exp_start = last_e + 1 + RL;
      exp_data  = rd_val(mem_m[a], rcnt_m[a], flip[a]);
      exp_err   = 1'b0;
    end else begin
      hitm = 1'b0;
      v = 32'h0;
      for (k = 0; k < LIMIT; k++) begin
        v = rd_val(mem_m[a], rcnt_m[a] + k, flip[a]);
        exp_bus[last_e + k * PERIOD] = '{id, 1'b0, a, 32'h0};
        if (((v ^ wd) & mk) == 32'h0) begin
          hitm = 1'b1;
          break;
        end
      end
      if (!hitm) k = LIMIT - 1;
      exp_start = last_e + k * PERIOD + 1 + RL;
      exp_data  = v;
      exp_err   = !hitm;
    end
    n_acc = id;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (n_acc != n_done && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_timeout", (n_acc != n_done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int g;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_poll  = 1'b0;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_mask  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // write addr 1 = 0x1
    issue(1'b1, 1'b0, 2'd1, 32'h1, 32'h0);
    wait_done();
    chk("wr_latency", rsp_first - last_e, 1);
    chk("wr_rsp_data", got_data, 32'h0);
    chk("wr_rsp_err", got_err, 0);

    // read addr 0 returning 0xA5
    issue(1'b1, 1'b0, 2'd0, 32'hA5, 32'h0);
    wait_done();
    issue(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    wait_done();
    chk("rd_latency", rsp_first - last_e, 2);
    chk("rd_rsp_data", got_data, 32'hA5);

    // poll addr 0, bit 0 rises on the 5th read
    issue(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    wait_done();
    flip[0] = 4;
    s = n_strobes;
    issue(1'b0, 1'b1, 2'd0, 32'h1, 32'h1);
    wait_done();
    chk("poll_reads", n_strobes - s, 5);
    chk("poll_spacing", strobe_gap, PERIOD);
    chk("poll_err", got_err, 0);
    chk("poll_data", got_data, 32'h0004_0001);

    // poll addr 2 never matches: limit reached
    issue(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
    wait_done();
    s = n_strobes;
    issue(1'b0, 1'b1, 2'd2, 32'h1, 32'h1);
    wait_done();
    chk("limit_reads", n_strobes - s, LIMIT);
    chk("limit_err", got_err, 1);
    chk("limit_data", got_data, 32'h0007_0000);

    // zero mask matches on the first read
    s = n_strobes;
    issue(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0);
    wait_done();
    chk("mask0_reads", n_strobes - s, 1);
    chk("mask0_err", got_err, 0);

    // response held for 10 cycles
    @(negedge clk);
    hold_low = 1'b1;
    issue(1'b0, 1'b0, 2'd1, 32'h0, 32'h0);
    g = 0;
    while (!bus.rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    chk("stall_valid", bus.rsp_valid, 1);
    chk("stall_data", bus.rsp_data, 32'h1);
    chk("stall_cmd_ready", bus.cmd_ready, 0);
    hold_low = 1'b0;
    wait_done();

    // reset during the read-wait of a poll
    issue(1'b0, 1'b1, 2'd2, 32'h1, 32'h1);
    s = n_rsp;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_chipselect", bus.chipselect, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", n_rsp - s, 0);
    issue(1'b1, 1'b0, 2'd3, 32'h5A, 32'h0);
    wait_done();
    chk("post_reset_wr", n_rsp - s, 1);
    chk("post_reset_wr_data", got_data, 32'h0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      int          t;
      logic [1:0]  a;
      logic [31:0] mk;
      t = $urandom_range(0, 2);
      a = 2'($urandom);
      case ($urandom_range(0, 3))
        0: mk = 32'h0;
        1: mk = 32'h1;
        2: mk = 32'h0003_0001;
        default: mk = $urandom;
      endcase
      flip[a] = $urandom_range(0, 6);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(t == 0, (t == 2) || (t == 0 && $urandom_range(0, 1) == 1), a,
            (t == 2) ? 32'h1 : $urandom, mk);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
